// File: rtl/uart_baudgen_frac.sv
// Fractional-N oversample tick generator for a UART.
// Produces an oversample tick, a bit-centre tick and a bit-end tick from a programmable divisor.
module uart_baudgen_frac #(
    parameter int               DIV_W       = 16,
    parameter int               FRAC_W      = 4,
    parameter int               OVS         = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(27)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              load,
    input  logic              sync_clr,
    output logic              tick_ovs,
    output logic              tick_mid,
    output logic              tick_bit
);

    localparam int               PH_W    = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q, pend_d;
    logic              tick_ovs_q, tick_ovs_d;
    logic              tick_mid_q, tick_mid_d;
    logic              tick_bit_q, tick_bit_d;

    logic              reload;
    logic              apply;
    logic [DIV_W-1:0]  sel_int;
    logic [FRAC_W-1:0] sel_frac;
    logic [DIV_W-1:0]  eff_m1;
    logic [FRAC_W:0]   frac_sum;

    always_comb begin
        reload   = clk_en && !sync_clr && (cnt_q == '0);
        apply    = sync_clr || reload;
        // A load in the same cycle as a reload/sync wins over anything older.
        sel_int  = load ? div_int  : (pend_q ? pend_int_q  : act_int_q);
        sel_frac = load ? div_frac : (pend_q ? pend_frac_q : act_frac_q);
        eff_m1   = (sel_int == '0) ? '0 : sel_int - DIV_W'(1);
        frac_sum = {1'b0, acc_q} + {1'b0, sel_frac};

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ph_d        = ph_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_d      = pend_q;
        tick_ovs_d  = 1'b0;
        tick_mid_d  = 1'b0;
        tick_bit_d  = 1'b0;

        if (load) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
            pend_d      = 1'b1;
        end

        if (apply) begin
            act_int_d  = sel_int;
            act_frac_d = sel_frac;
            pend_d     = 1'b0;
        end

        if (sync_clr) begin
            cnt_d = eff_m1;
            acc_d = '0;
            ph_d  = '0;
        end else if (reload) begin
            // Carry out of the fraction accumulator stretches this period by one cycle.
            cnt_d      = eff_m1 + DIV_W'(frac_sum[FRAC_W]);
            acc_d      = frac_sum[FRAC_W-1:0];
            ph_d       = ph_q + PH_W'(1);
            tick_ovs_d = 1'b1;
            tick_mid_d = (ph_q == PH_MID);
            tick_bit_d = (ph_q == PH_LAST);
        end else if (clk_en) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            ph_q        <= '0;
            act_int_q   <= DEFAULT_DIV;
            act_frac_q  <= '0;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            tick_ovs_q  <= 1'b0;
            tick_mid_q  <= 1'b0;
            tick_bit_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ph_q        <= ph_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            tick_ovs_q  <= tick_ovs_d;
            tick_mid_q  <= tick_mid_d;
            tick_bit_q  <= tick_bit_d;
        end
    end

    assign tick_ovs = tick_ovs_q;
    assign tick_mid = tick_mid_q;
    assign tick_bit = tick_bit_q;

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Bench for uart_baudgen_frac: directed scenarios plus random traffic, each cycle checked
// against a period/phase model built from reload counts and a running fraction total.
module tb_uart_baudgen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              clk_en   = 1'b0;
    logic              load     = 1'b0;
    logic              sync_clr = 1'b0;
    logic [DIV_W-1:0]  div_int  = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              tick_ovs;
    logic              tick_mid;
    logic              tick_bit;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: enabled cycles left before the next tick, divisor pairs,
    // total fraction added since the last alignment, reloads since the last alignment.
    int m_left, m_act_i, m_act_f, m_pend, m_pend_i, m_pend_f, m_ftot, m_nrel;
    bit m_ovs, m_mid, m_bit;

    always #5 clk = ~clk;

    uart_baudgen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEFAULT_DIV(DIV_W'(27))
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .div_int(div_int), .div_frac(div_frac),
        .load(load), .sync_clr(sync_clr),
        .tick_ovs(tick_ovs), .tick_mid(tick_mid), .tick_bit(tick_bit)
    );

    task automatic model_reset();
        m_left = 0; m_act_i = 27; m_act_f = 0;
        m_pend = 0; m_pend_i = 0; m_pend_f = 0;
        m_ftot = 0; m_nrel = 0;
        m_ovs = 0; m_mid = 0; m_bit = 0;
    endtask

    task automatic model_step(input bit en, input bit ld, input bit sc, input int di, input int df);
        int si, sf, e, c;
        si = ld ? di : (m_pend != 0 ? m_pend_i : m_act_i);
        sf = ld ? df : (m_pend != 0 ? m_pend_f : m_act_f);
        e  = (si == 0) ? 1 : si;
        m_ovs = 0; m_mid = 0; m_bit = 0;
        if (sc || (en && m_left == 0)) begin
            m_act_i = si; m_act_f = sf; m_pend = 0;
            if (sc) begin
                m_left = e - 1; m_ftot = 0; m_nrel = 0;
            end else begin
                c = (m_ftot + sf) / (1 << FRAC_W) - m_ftot / (1 << FRAC_W);
                m_ftot = m_ftot + sf;
                m_left = e - 1 + c;
                m_ovs = 1;
                m_mid = ((m_nrel % OVS) == OVS / 2 - 1);
                m_bit = ((m_nrel % OVS) == OVS - 1);
                m_nrel++;
            end
        end else begin
            if (en) m_left--;
            if (ld) begin
                m_pend = 1; m_pend_i = di; m_pend_f = df;
            end
        end
    endtask

    // One clock: drive, advance the model, then compare all three ticks 1 time unit after the edge.
    task automatic cycle(input bit en, input bit ld, input bit sc, input int di, input int df);
        clk_en = en; load = ld; sync_clr = sc;
        div_int = DIV_W'(di); div_frac = FRAC_W'(df);
        model_step(en, ld, sc, di, df);
        @(posedge clk); #1;
        clk_en = 1'b0; load = 1'b0; sync_clr = 1'b0;
        n_vec++;
        if (tick_ovs !== m_ovs) begin
            n_err++; $display("FAIL tick_ovs t=%0t got %b exp %b", $time, tick_ovs, m_ovs);
        end
        n_vec++;
        if (tick_mid !== m_mid) begin
            n_err++; $display("FAIL tick_mid t=%0t got %b exp %b", $time, tick_mid, m_mid);
        end
        n_vec++;
        if (tick_bit !== m_bit) begin
            n_err++; $display("FAIL tick_bit t=%0t got %b exp %b", $time, tick_bit, m_bit);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_vec++;
        if ({tick_ovs, tick_mid, tick_bit} !== 3'b000) begin
            n_err++; $display("FAIL reset_ticks got %b exp 000", {tick_ovs, tick_mid, tick_bit});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        cycle(1, 0, 0, 0, 0);
        n_vec++;
        if (tick_ovs !== 1'b1) begin
            n_err++; $display("FAIL first_tick_after_reset got %b exp 1", tick_ovs);
        end
    endtask

    task automatic test_div4();
        int n_ovs, n_mid, n_bit, first_mid, first_bit;
        n_ovs = 0; n_mid = 0; n_bit = 0; first_mid = 0; first_bit = 0;
        cycle(1, 1, 1, 4, 0);
        for (int i = 1; i <= 128; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (tick_ovs === 1'b1) n_ovs++;
            if (tick_mid === 1'b1) begin n_mid++; if (first_mid == 0) first_mid = i; end
            if (tick_bit === 1'b1) begin n_bit++; if (first_bit == 0) first_bit = i; end
        end
        n_vec++;
        if (n_ovs !== 32) begin n_err++; $display("FAIL div4_ovs_count got %0d exp 32", n_ovs); end
        n_vec++;
        if (n_mid !== 2) begin n_err++; $display("FAIL div4_mid_count got %0d exp 2", n_mid); end
        n_vec++;
        if (n_bit !== 2) begin n_err++; $display("FAIL div4_bit_count got %0d exp 2", n_bit); end
        n_vec++;
        if (first_mid !== 32) begin n_err++; $display("FAIL div4_mid_pos got %0d exp 32", first_mid); end
        n_vec++;
        if (first_bit !== 64) begin n_err++; $display("FAIL div4_bit_pos got %0d exp 64", first_bit); end
    endtask

    task automatic test_frac();
        int idx[$];
        cycle(1, 1, 1, 4, 8);
        for (int i = 1; i <= 200; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (tick_ovs === 1'b1) idx.push_back(i);
        end
        n_vec++;
        if (idx.size() < 34) begin
            n_err++; $display("FAIL frac_tick_count got %0d exp >=34", idx.size());
        end else begin
            if (idx[32] - idx[0] !== 144) begin
                n_err++; $display("FAIL frac_span32 got %0d exp 144", idx[32] - idx[0]);
            end
            n_vec++;
            if ((idx[2] - idx[1]) + (idx[3] - idx[2]) !== 9 || idx[2] - idx[1] == idx[3] - idx[2]) begin
                n_err++; $display("FAIL frac_alternate got %0d,%0d exp 4/5 pair",
                                  idx[2] - idx[1], idx[3] - idx[2]);
            end
        end
    endtask

    task automatic test_div0_sparse();
        int n_en, n_tick;
        bit en;
        n_en = 0; n_tick = 0;
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 60; i++) begin
            en = (i % 3 == 2);
            cycle(en, 0, 0, 0, 0);
            if (en) n_en++;
            if (tick_ovs === 1'b1) n_tick++;
        end
        n_vec++;
        if (n_tick !== n_en) begin
            n_err++; $display("FAIL div0_tick_count got %0d exp %0d", n_tick, n_en);
        end
    endtask

    task automatic test_load_midperiod();
        int idx[$];
        cycle(1, 1, 1, 10, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 3, 0);
        for (int i = 2; i <= 20; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (tick_ovs === 1'b1) idx.push_back(i);
        end
        n_vec++;
        if (idx.size() < 3) begin
            n_err++; $display("FAIL load_mid_ticks got %0d exp >=3", idx.size());
        end else begin
            if (idx[0] !== 7) begin
                n_err++; $display("FAIL load_mid_first got %0d exp 7", idx[0]);
            end
            n_vec++;
            if (idx[1] - idx[0] !== 3 || idx[2] - idx[1] !== 3) begin
                n_err++; $display("FAIL load_mid_period got %0d,%0d exp 3,3",
                                  idx[1] - idx[0], idx[2] - idx[1]);
            end
        end
    endtask

    task automatic test_sync_mid();
        int first_mid, first_bit;
        first_mid = 0; first_bit = 0;
        cycle(1, 1, 1, 4, 0);
        for (int i = 0; i < 39; i++) cycle(1, 0, 0, 0, 0);
        // This cycle would otherwise be the 10th reload (phase 9).
        cycle(1, 0, 1, 0, 0);
        n_vec++;
        if (tick_ovs !== 1'b0) begin n_err++; $display("FAIL sync_no_tick got %b exp 0", tick_ovs); end
        for (int i = 1; i <= 64; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (tick_mid === 1'b1 && first_mid == 0) first_mid = i;
            if (tick_bit === 1'b1 && first_bit == 0) first_bit = i;
        end
        n_vec++;
        if (first_mid !== 32) begin n_err++; $display("FAIL sync_mid_pos got %0d exp 32", first_mid); end
        n_vec++;
        if (first_bit !== 64) begin n_err++; $display("FAIL sync_bit_pos got %0d exp 64", first_bit); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_async_reset();
        int idx[$];
        cycle(1, 1, 1, 1, 0);
        cycle(1, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (tick_ovs !== 1'b0) begin n_err++; $display("FAIL async_clear_ovs got %b exp 0", tick_ovs); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 9, 0);
        cycle(1, 0, 0, 0, 0);
        #3 reset = 1'b0;
        #1;
        n_vec++;
        if ({tick_ovs, tick_mid, tick_bit} !== 3'b000) begin
            n_err++; $display("FAIL async_clear_all got %b exp 000", {tick_ovs, tick_mid, tick_bit});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        for (int i = 1; i <= 60; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (tick_ovs === 1'b1) idx.push_back(i);
        end
        n_vec++;
        if (idx.size() < 3) begin
            n_err++; $display("FAIL async_ticks got %0d exp >=3", idx.size());
        end else begin
            if (idx[0] !== 1) begin n_err++; $display("FAIL async_first got %0d exp 1", idx[0]); end
            n_vec++;
            if (idx[1] - idx[0] !== 27) begin
                n_err++; $display("FAIL async_default_period got %0d exp 27", idx[1] - idx[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_frac();
        test_div0_sparse();
        test_load_midperiod();
        test_sync_mid();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
